// File: rtl/btn_debounce.sv
// Push-button debouncer: multi-flop synchronizer, four-state qualification FSM
// with a saturating stable counter, registered level plus one-cycle press and
// release strobes intended as clock enables for downstream logic.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;

  assign btn_sync = sync_q[SYNC_STAGES-1];

  // Synchronizer chain bringing the asynchronous button into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
    end
  end

  // Qualification FSM; level and strobes are registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (btn_sync) state <= PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!btn_sync) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state     <= PRESSED;
            cnt       <= '0;
            btn_level <= 1'b1;
            btn_press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          cnt <= '0;
          if (!btn_sync) state <= RELEASE_WAIT;
        end
        RELEASE_WAIT: begin
          if (btn_sync) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state       <= IDLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          btn_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: run-length model of the synchronized button checked
// every cycle, plus directed scenarios with literal cycle expectations.
module tb_btn_debounce;

  localparam int unsigned DC = 4;
  localparam int unsigned SS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic btn_level, btn_press, btn_release;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int press_seen = 0;
  int rel_seen = 0;

  always #5 clk = ~clk;

  btn_debounce #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  // Model: raw samples delayed SS edges; level flips once DC+1 consecutive
  // observed samples disagree with it.
  logic hist [SS];
  logic obs;
  int   run = 0;
  logic m_level = 1'b0;
  logic m_press = 1'b0;
  logic m_rel   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SS; i++) hist[i] = 1'b0;
      run = 0; m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0;
    end else begin
      obs = hist[SS-1];
      m_press = 1'b0;
      m_rel   = 1'b0;
      if (obs != m_level) begin
        run++;
        if (run == DC + 1) begin
          m_level = obs;
          m_press = obs;
          m_rel   = ~obs;
          run     = 0;
        end
      end else begin
        run = 0;
      end
      for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = btn;
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_level", btn_level, m_level);
      check("model_press", btn_press, m_press);
      check("model_release", btn_release, m_rel);
      check("no_x", $isunknown({btn_level, btn_press, btn_release}), 1'b0);
      check("press_rel_excl", btn_press & btn_release, 1'b0);
      if (btn_press === 1'b1) press_seen++;
      if (btn_release === 1'b1) rel_seen++;
    end
  end

  int p0, r0, off, w;

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_level", btn_level, 1'b0);
    check("rst_press", btn_press, 1'b0);
    check("rst_release", btn_release, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Clean press
    r0 = rel_seen;
    btn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("clean_press_t", btn_press, 1'(i == 6));
      check("clean_level_t", btn_level, 1'(i >= 6));
    end
    check_int("clean_no_release", rel_seen - r0, 0);

    // Release
    btn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("release_t", btn_release, 1'(i == 6));
      check("release_level_t", btn_level, 1'(i < 6));
    end

    // Bounce 1,0,1,0 two cycles each, then held high
    p0 = press_seen;
    btn = 1'b1; repeat (2) @(negedge clk);
    btn = 1'b0; repeat (2) @(negedge clk);
    btn = 1'b1; repeat (2) @(negedge clk);
    btn = 1'b0; repeat (2) @(negedge clk);
    btn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("bounce_press_t", btn_press, 1'(i == 6));
    end
    check_int("bounce_one_press", press_seen - p0, 1);
    btn = 1'b0;
    repeat (12) @(negedge clk);

    // Long hold
    p0 = press_seen;
    btn = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i >= 6) check("hold_level", btn_level, 1'b1);
    end
    check_int("hold_one_press", press_seen - p0, 1);
    btn = 1'b0;
    repeat (12) @(negedge clk);

    // Reset in the last qualification cycle
    p0 = press_seen;
    btn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("prerst_press", btn_press, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("inrst_level", btn_level, 1'b0);
    check("inrst_press", btn_press, 1'b0);
    check("inrst_release", btn_release, 1'b0);
    rst = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      check("postrst_press_t", btn_press, 1'(j == 6));
      check("postrst_level_t", btn_level, 1'(j >= 6));
    end
    check_int("rst_one_press", press_seen - p0, 1);
    btn = 1'b0;
    repeat (12) @(negedge clk);

    // Sub-cycle glitches at random phase, never coinciding with a rising edge
    p0 = press_seen;
    for (int k = 0; k < 10000; k++) begin
      @(posedge clk);
      off = int'($urandom_range(1, 9));
      w   = int'($urandom_range(1, 9));
      if (off + w == 10) w = (w < 9) ? w + 1 : w - 1;
      #(off) btn = 1'b1;
      #(w)   btn = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    repeat (12) @(negedge clk);
    check_int("glitch_no_press", press_seen - p0, 0);
    check("glitch_level", btn_level, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive stable clk cycles required to accept a level change (10 ms at 100 MHz); legal minimum is 2.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the depth of the input synchronizer flop chain; legal minimum is 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all flops are on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port btn, input, 1 bit: raw, asynchronous, bouncing push-button level (1 = pressed).
REQ-006 The block SHALL have port btn_level, output, 1 bit: debounced button level.
REQ-007 The block SHALL have port btn_press, output, 1 bit: a one-clk pulse marking each accepted press, for the downstream LED counter.
REQ-008 The block SHALL have port btn_release, output, 1 bit: a one-clk pulse marking each accepted release.

Function
REQ-009 btn SHALL pass through a SYNC_STAGES flop chain; only the last stage (btn_sync) SHALL feed any other logic.
REQ-010 The FSM SHALL have four states: IDLE (stable released), PRESS_WAIT, PRESSED (stable pressed) and RELEASE_WAIT.
REQ-011 The stable counter SHALL be ceil(log2(DEBOUNCE_CYCLES)) bits wide, or 1 bit if that is smaller; it SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-012 In IDLE, btn_sync=1 SHALL move the FSM to PRESS_WAIT with counter=0; btn_sync=0 SHALL keep IDLE with counter=0.
REQ-013 In PRESS_WAIT, btn_sync=0 SHALL return the FSM to IDLE with counter=0, rejecting the bounce with no pulse.
REQ-014 In PRESS_WAIT, btn_sync=1 with counter<DEBOUNCE_CYCLES-1 SHALL increment the counter.
REQ-015 In PRESS_WAIT, btn_sync=1 with counter=DEBOUNCE_CYCLES-1 SHALL move the FSM to PRESSED and clear the counter.
REQ-016 PRESSED, RELEASE_WAIT and the transition to IDLE SHALL mirror REQ-012 to REQ-015 with btn_sync inverted.
REQ-017 btn_level SHALL be a registered output equal to 1 exactly while the state is PRESSED or RELEASE_WAIT.
REQ-018 btn_press SHALL be registered and high for exactly the single cycle after the PRESS_WAIT->PRESSED transition.
REQ-019 btn_release SHALL be registered and high for exactly the single cycle after the RELEASE_WAIT->IDLE transition.
REQ-020 btn_press and btn_release SHALL never be high in the same cycle.
REQ-021 Latency: with btn stable high from the edge that first samples it, btn_press SHALL be high in cycle SYNC_STAGES+DEBOUNCE_CYCLES counted from that edge; release latency SHALL be identical.
REQ-022 A bounce that toggles btn_sync at any counter value short of DEBOUNCE_CYCLES-1 SHALL restart qualification from counter=0 in the original stable state.
REQ-023 Holding the button indefinitely SHALL produce exactly one btn_press pulse and no repeat.
REQ-024 btn_press is synchronous to clk; downstream logic SHALL use it as a clock enable, never as a clock.

Reset
REQ-025 At any clk edge with rst=1, the block SHALL force: all synchronizer flops=0, state=IDLE, counter=0, btn_level=0, btn_press=0, btn_release=0.
REQ-026 rst SHALL take priority over every FSM transition and over pulse generation.
REQ-027 If rst is asserted during PRESS_WAIT or RELEASE_WAIT, no pulse SHALL be emitted for the interrupted qualification.
REQ-028 If the button is still held when rst deasserts, the block SHALL requalify from IDLE and emit one new btn_press after REQ-021 latency.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-029 Clean press: btn 0->1 held -> btn_press high for exactly 1 cycle at cycle 6, btn_level=1 from cycle 6 onward, btn_release=0 throughout.
REQ-030 Bounce rejection: btn pulses 1,0,1,0 with each level lasting 2 cycles, then held at 1 -> exactly one btn_press, at 6 cycles after the final rise.
REQ-031 Release: press accepted, then btn held at 0 -> btn_release high for 1 cycle at cycle 6 after the fall, btn_level=0 from that cycle onward.
REQ-032 Long hold: btn high for 1000 cycles -> exactly one btn_press pulse, btn_level constant at 1.
REQ-033 Reset mid-qualification: rst pulsed for 1 cycle at cycle 4 of PRESS_WAIT with btn held -> no pulse at the original time, one btn_press 6 cycles after rst deasserts, all outputs 0 during rst.
REQ-034 Glitch shorter than 1 clk, asynchronous to clk, applied 10000 times at random phase -> no X propagation, and no btn_press without 4 consecutive synchronized high samples.
